// File: rtl/lfsr_checker.sv
// Serial LFSR sequence checker: self-synchronises to an LFSR bit stream, then
// flags every bit that deviates from the predicted sequence and counts them.

module lfsr_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (inc && count != '1)
      count <= count + 1'b1;
  end
endmodule

module lfsr_checker #(
  parameter int               WIDTH      = 7,
  parameter logic [WIDTH-1:0] TAPS       = 7'b1100000,
  parameter int               LOCK_CNT   = 16,
  parameter int               UNLOCK_ERR = 4,
  parameter int               CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_ERR + 1);
  localparam logic [FW-1:0] FILL_LAST  = FW'(WIDTH - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST   = BW'(UNLOCK_ERR - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [MW-1:0]     match_q, match_d;
  logic [BW-1:0]     bad_q, bad_d;
  logic              pulse_d;
  logic [1:0]        inc;
  logic [1:0][CNT_W-1:0] cnt;

  logic pred, mis, good;
  assign pred = ^(sr_q & TAPS);
  assign mis  = (din != pred);
  // An all-zero register predicts 0 forever; never let it count towards lock.
  assign good = !mis && (sr_q != '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEARCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        SEARCH:  if (fill_q == FILL_LAST)            state_d = VERIFY;
        VERIFY:  if (good && match_q == MATCH_LAST)  state_d = LOCKED;
        LOCKED:  if (mis && bad_q == BAD_LAST)       state_d = SEARCH;
        default:                                     state_d = SEARCH;
      endcase
    end
  end

  // Counters not owned by the current state sit at zero, so every entry
  // into a state starts from a clean count.
  always_comb begin
    sr_d    = sr_q;
    fill_d  = fill_q;
    match_d = match_q;
    bad_d   = bad_q;
    pulse_d = 1'b0;
    inc     = 2'b00;
    if (enable) begin
      case (state_q)
        SEARCH: begin
          sr_d   = {sr_q[WIDTH-2:0], din};
          fill_d = (fill_q == FILL_LAST) ? '0 : fill_q + 1'b1;
        end
        VERIFY: begin
          sr_d    = {sr_q[WIDTH-2:0], din};
          match_d = (good && match_q != MATCH_LAST) ? match_q + 1'b1 : '0;
        end
        LOCKED: begin
          // Free-run on the prediction so a flipped bit cannot corrupt sr.
          sr_d   = {sr_q[WIDTH-2:0], pred};
          inc[0] = 1'b1;
          if (mis) begin
            pulse_d = 1'b1;
            inc[1]  = 1'b1;
            bad_d   = (bad_q == BAD_LAST) ? '0 : bad_q + 1'b1;
          end else if (bad_q != '0) begin
            bad_d = bad_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      bad_q     <= '0;
      err_pulse <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      bad_q     <= bad_d;
      err_pulse <= pulse_d;
    end
  end

  assign locked = (state_q == LOCKED);

  // cnt[0] = bit_count, cnt[1] = err_count
  for (genvar i = 0; i < 2; i++) begin : g_cnt
    lfsr_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (inc[i]),
      .count (cnt[i])
    );
  end

  assign bit_count = cnt[0];
  assign err_count = cnt[1];
endmodule
